// File: rtl/sbox_share_ctrl_pkg.sv
// Shared types and constants for the time-multiplexed S-box engine.
// Used by sbox_share_ctrl (optional SBOX_PIPE_EN output register).
package aes_sbox_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic {
        JOB_ST,
        JOB_KW
    } job_t;

    localparam int AES_STATE_BYTES = 16;
    localparam int AES_WORD_BYTES  = 4;

    function automatic int passes(input int nbytes, input int nsb);
        return (nbytes / nsb < 1) ? 1 : nbytes / nsb;
    endfunction

endpackage

// File: rtl/sbox_share_ctrl_sbox.sv
// Combinational AES forward S-box lookup.
// Table row r holds the outputs for inputs 16*r .. 16*r+15.
module S_box (
    input  logic [7:0] b,
    output logic [7:0] b_
);

    localparam logic [2047:0] T = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // entry 0 sits in the top byte, so 255-b = ~b selects it
    assign b_ = T[{~b, 3'b000} +: 8];

endmodule

// File: rtl/sbox_share_ctrl.sv
// Shares NSB S-boxes between the AES state path and key expansion.
// Define SBOX_PIPE_EN to register S-box outputs (adds one cycle).
module sbox_share_ctrl
    import aes_sbox_pkg::*;
#(
    parameter int NSB = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_req_valid,
    output logic         st_req_ready,
    input  logic [127:0] st_req_data,
    output logic         st_rsp_valid,
    output logic [127:0] st_rsp_data,
    input  logic         kw_req_valid,
    output logic         kw_req_ready,
    input  logic [31:0]  kw_req_data,
    output logic         kw_rsp_valid,
    output logic [31:0]  kw_rsp_data,
    output logic         busy
);

    localparam int CW   = 8 * NSB;
    localparam int P_ST = passes(AES_STATE_BYTES, NSB);
    localparam int P_KW = passes(AES_WORD_BYTES, NSB);

    if (!(NSB == 1 || NSB == 2 || NSB == 4)) begin : g_bad_nsb
        $error("sbox_share_ctrl: NSB must be 1, 2 or 4");
    end

    state_t         state, state_n;
    job_t           job;
    logic           last_kw;
    logic [4:0]     cnt, npass, pidx, wr_idx;
    logic [6:0]     poff, woff;
    logic [127:0]   work, res;
    logic [CW-1:0]  sb_in, sb_out, wr_data;
    logic           gnt_st, gnt_kw, accept, wr_en, run_end;

    // round-robin: key wins a tie unless it had the previous job
    always_comb begin
        gnt_kw = kw_req_valid & (~st_req_valid | ~last_kw);
        gnt_st = st_req_valid & ~gnt_kw;
    end

    assign st_req_ready = (state == IDLE) & ~rst & gnt_st;
    assign kw_req_ready = (state == IDLE) & ~rst & gnt_kw;
    assign accept       = st_req_ready | kw_req_ready;

    assign st_rsp_valid = (state == DONE) & ~rst & (job == JOB_ST);
    assign kw_rsp_valid = (state == DONE) & ~rst & (job == JOB_KW);
    assign busy         = (state != IDLE) & ~rst;
    assign st_rsp_data  = res;
    assign kw_rsp_data  = res[31:0];

    assign npass = (job == JOB_ST) ? 5'(P_ST) : 5'(P_KW);
    assign pidx  = (cnt < npass) ? cnt : 5'd0;
    assign poff  = 7'(CW * int'(pidx));
    assign woff  = 7'(CW * int'(wr_idx));
    assign sb_in = work[poff +: CW];

    for (genvar g = 0; g < NSB; g++) begin : g_sbox
        S_box u_sbox (
            .b  (sb_in[8*g +: 8]),
            .b_ (sb_out[8*g +: 8])
        );
    end

`ifdef SBOX_PIPE_EN
    logic [CW-1:0] sb_q;

    always_ff @(posedge clk) begin
        if (rst) sb_q <= '0;
        else     sb_q <= sb_out;
    end

    // chunk k is presented at cnt=k and written at cnt=k+1
    assign wr_en   = (state == RUN) && (cnt != 5'd0);
    assign wr_idx  = cnt - 5'd1;
    assign wr_data = sb_q;
    assign run_end = (cnt == npass);
`else
    assign wr_en   = (state == RUN);
    assign wr_idx  = cnt;
    assign wr_data = sb_out;
    assign run_end = (cnt == npass - 5'd1);
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept)  state_n = RUN;
            RUN:     if (run_end) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            job     <= JOB_ST;
            last_kw <= 1'b0;
            work    <= '0;
            res     <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                work    <= st_req_ready ? st_req_data : {96'd0, kw_req_data};
                cnt     <= '0;
                job     <= st_req_ready ? JOB_ST : JOB_KW;
                last_kw <= kw_req_ready;
            end else if (state == RUN) begin
                cnt <= cnt + 5'd1;
            end
            if (wr_en) res[woff +: CW] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed self-checking bench for sbox_share_ctrl (NSB = 4, 1, 2).
// Expected latencies follow the SBOX_PIPE_EN build setting.
module tb_sbox_share_ctrl;

`ifdef SBOX_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         st_v = 1'b0, kw_v = 1'b0, s1_v = 1'b0, s2_v = 1'b0;
    logic [127:0] st_d = '0;
    logic [31:0]  kw_d = '0;
    logic         st_rdy, kw_rdy, st_rv, kw_rv, busy;
    logic [127:0] st_rd;
    logic [31:0]  kw_rd;
    logic         s1_rdy, k1_rdy, s1_rv, k1_rv, b1;
    logic [127:0] s1_rd;
    logic [31:0]  k1_rd;
    logic         s2_rdy, k2_rdy, s2_rv, k2_rv, b2;
    logic [127:0] s2_rd;
    logic [31:0]  k2_rd;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    sbox_share_ctrl #(.NSB(4)) u4 (
        .clk(clk), .rst(rst),
        .st_req_valid(st_v), .st_req_ready(st_rdy), .st_req_data(st_d),
        .st_rsp_valid(st_rv), .st_rsp_data(st_rd),
        .kw_req_valid(kw_v), .kw_req_ready(kw_rdy), .kw_req_data(kw_d),
        .kw_rsp_valid(kw_rv), .kw_rsp_data(kw_rd),
        .busy(busy)
    );

    sbox_share_ctrl #(.NSB(1)) u1 (
        .clk(clk), .rst(rst),
        .st_req_valid(s1_v), .st_req_ready(s1_rdy), .st_req_data(st_d),
        .st_rsp_valid(s1_rv), .st_rsp_data(s1_rd),
        .kw_req_valid(1'b0), .kw_req_ready(k1_rdy), .kw_req_data(32'd0),
        .kw_rsp_valid(k1_rv), .kw_rsp_data(k1_rd),
        .busy(b1)
    );

    sbox_share_ctrl #(.NSB(2)) u2 (
        .clk(clk), .rst(rst),
        .st_req_valid(s2_v), .st_req_ready(s2_rdy), .st_req_data(st_d),
        .st_rsp_valid(s2_rv), .st_rsp_data(s2_rd),
        .kw_req_valid(1'b0), .kw_req_ready(k2_rdy), .kw_req_data(32'd0),
        .kw_rsp_valid(k2_rv), .kw_rsp_data(k2_rd),
        .busy(b2)
    );

    always @(posedge clk) if (st_rv || kw_rv) pulses <= pulses + 1;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy_of(input int sel, input bit kw);
        case (sel)
            1:       return s1_rdy;
            2:       return s2_rdy;
            default: return kw ? kw_rdy : st_rdy;
        endcase
    endfunction

    function automatic logic rv_of(input int sel, input bit kw);
        case (sel)
            1:       return s1_rv;
            2:       return s2_rv;
            default: return kw ? kw_rv : st_rv;
        endcase
    endfunction

    function automatic logic [127:0] rd_of(input int sel, input bit kw);
        case (sel)
            1:       return s1_rd;
            2:       return s2_rd;
            default: return kw ? {96'd0, kw_rd} : st_rd;
        endcase
    endfunction

    task automatic set_v(input int sel, input bit kw, input logic v);
        case (sel)
            1:       s1_v = v;
            2:       s2_v = v;
            default: if (kw) kw_v = v; else st_v = v;
        endcase
    endtask

    task automatic job(input int sel, input bit kw, input logic [127:0] d,
                       input int lat, input logic [127:0] exp,
                       input string tag);
        int k;
        bit got;
        if (kw) kw_d = d[31:0];
        else    st_d = d;
        set_v(sel, kw, 1'b1);
        #1;
        k = 0;
        while (!rdy_of(sel, kw) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready"}, {127'd0, rdy_of(sel, kw)}, 128'd1);
        @(posedge clk);
        #1 set_v(sel, kw, 1'b0);
        got = 1'b0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rv_of(sel, kw)) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_latency"}, got ? 128'(k) : '1, 128'(lat));
        chk({tag, "_data"}, rd_of(sel, kw), exp);
        @(negedge clk);
        chk({tag, "_pulse1"}, {127'd0, rv_of(sel, kw)}, 128'd0);
    endtask

    localparam logic [127:0] V_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] V_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    initial begin
        int k;
        int p0;

        // reset: ready gated even with a pending request
        st_v = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_st_ready", {127'd0, st_rdy}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_rsp_valid", {126'd0, st_rv, kw_rv}, 128'd0);
        chk("rst_st_data", st_rd, 128'd0);
        chk("rst_kw_data", {96'd0, kw_rd}, 128'd0);
        st_v = 1'b0;
        rst  = 1'b0;
        @(negedge clk);

        job(0, 1'b0, V_IN, 5 + PIPE, V_OUT, "st_vec");
        job(0, 1'b1, {96'd0, 32'hcf4f3c09}, 2 + PIPE,
            {96'd0, 32'h8a84eb01}, "kw_vec");

        // arbitration: last job was a key job, but flag came from it,
        // so re-run from reset for a clean last_kw=0 start
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        st_d = V_IN;
        kw_d = 32'hcf4f3c09;
        st_v = 1'b1;
        kw_v = 1'b1;
        #1;
        chk("arb_grant1", {126'd0, st_rdy, kw_rdy}, 128'b01);
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(st_rdy || kw_rdy) && k < 20);
        chk("arb_occ_kw", 128'(k), 128'(3 + PIPE));
        chk("arb_grant2", {126'd0, st_rdy, kw_rdy}, 128'b10);
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(st_rdy || kw_rdy) && k < 20);
        chk("arb_occ_st", 128'(k), 128'(6 + PIPE));
        chk("arb_grant3", {126'd0, st_rdy, kw_rdy}, 128'b01);
        @(posedge clk);
        #1;
        st_v = 1'b0;
        kw_v = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 20);
        chk("arb_idle", {127'd0, busy}, 128'd0);

        // byte sweeps on each bank size
        job(0, 1'b0, {16{8'h00}}, 5 + PIPE, {16{8'h63}}, "sw4_00");
        job(0, 1'b0, {16{8'hff}}, 5 + PIPE, {16{8'h16}}, "sw4_ff");
        job(1, 1'b0, {16{8'h00}}, 17 + PIPE, {16{8'h63}}, "sw1_00");
        job(1, 1'b0, {16{8'hff}}, 17 + PIPE, {16{8'h16}}, "sw1_ff");
        job(2, 1'b0, {16{8'h00}}, 9 + PIPE, {16{8'h63}}, "sw2_00");
        job(2, 1'b0, {16{8'hff}}, 9 + PIPE, {16{8'h16}}, "sw2_ff");

        // reset in the middle of a state job
        st_d = V_IN;
        st_v = 1'b1;
        p0 = pulses;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", {127'd0, busy}, 128'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", {127'd0, st_rdy}, 128'd0);
        @(negedge clk);
        chk("mid_rst_data", st_rd, 128'd0);
        rst = 1'b0;
        #1;
        chk("mid_ready_back", {127'd0, st_rdy}, 128'd1);
        chk("mid_no_pulse", 128'(pulses - p0), 128'd0);
        job(0, 1'b0, V_IN, 5 + PIPE, V_OUT, "mid_rerun");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sbox_share_ctrl.md
# sbox_share_ctrl

Time-multiplexed SubBytes/SubWord engine that shares a small bank of `S_box` instances between two requesters: the AES round datapath (128-bit state) and the key-expansion unit (32-bit word). It arbitrates requests, sequences chunks through the shared S-boxes over several cycles and returns the substituted data. It sits between the round controller, the key scheduler and the `S_box` lookups, and replaces per-byte S-box replication.

## Interface
- `NSB`, 4: number of shared `S_box` instances.
  - Legal values are 1, 2 and 4; anything else is an elaboration error.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `st_req_valid` in 1: state request.
- `st_req_ready` out 1: state request accepted when valid & ready.
- `st_req_data` in 128: state to substitute.
- `st_rsp_valid` out 1: one-cycle pulse, state result valid.
- `st_rsp_data` out 128: substituted state.
- `kw_req_valid` in 1: key-word request.
- `kw_req_ready` out 1: key-word accept.
- `kw_req_data` in 32: word to substitute (SubWord).
- `kw_rsp_valid` out 1: one-cycle pulse, word result valid.
- `kw_rsp_data` out 32: substituted word.
- `busy` out 1: high whenever not IDLE.

## Operation
- States:
  - IDLE: ready outputs may assert.
  - RUN: the chunk counter `cnt` steps once per cycle.
  - DONE: the response pulse is driven for one cycle, then the FSM returns to IDLE.
- Pass count `P`:
  - State job: 16/NSB.
  - Word job: 4/NSB, minimum 1.
- Arbitration in IDLE:
  - If only one `*_req_valid` is high, that requester is granted.
  - If both are high, the grant goes round-robin. Flag `last_kw` = 1 after a key job. With both pending, key wins when `last_kw`=0, otherwise state wins. `last_kw` resets to 0.
  - Only the granted requester sees ready=1 in that cycle: `*_req_ready` = IDLE & ~rst & grant.
- On accept:
  - Input data is latched into the work register.
  - `cnt`=0; the job type is recorded; the FSM moves to RUN.
- RUN:
  - Chunk `cnt` is the bit range `[8*NSB*cnt +: 8*NSB]`, where lane j is byte j of the chunk.
  - Each S-box output is written to the same position in the 128-bit result register.
  - After chunk P-1 is written, the FSM goes to DONE.
- DONE:
  - The matching `*_rsp_valid` is high for exactly one cycle. There is no back-pressure; the consumer must capture.
- Result data:
  - `st_rsp_data` is the full result register.
  - `kw_rsp_data` is result[31:0].
  - Both hold their value until the next job's first write. The value is only meaningful while the matching valid is high.
- Requests arriving while busy wait; `valid` must be held until ready.
- Reset mid-job: the job is dropped and no response is issued. After reset the FSM is in IDLE, `last_kw`=0, registers are 0.

## Timing
- Reset values:
  - `st_req_ready`, `kw_req_ready`, `st_rsp_valid`, `kw_rsp_valid`, `busy` = 0 while rst is high.
  - `st_rsp_data` = 0 and `kw_rsp_data` = 0.
- Accept at edge E0. RUN occupies P cycles. The response pulse is in the cycle after RUN ends, so latency from accept edge to pulse is P+1 cycles.
- Latency with NSB=4:
  - State job: 5 cycles.
  - Word job: 2 cycles.
- Occupancy: IDLE is re-entered after DONE, so there are P+2 cycles between back-to-back accepts.
- Ready is never asserted in RUN or DONE.

## Configuration
- `SBOX_PIPE_EN`:
  - Defined: S-box outputs are registered before the write into the result register. RUN lasts P+1 cycles (write of chunk k occurs one cycle after it is presented), so latency becomes P+2.
  - Undefined: S-box lookups are combinational within the cycle, with timing as above.
  - Arbitration and handshakes are identical in both builds.

## Structure
- Package `aes_sbox_pkg` holds:
  - FSM state enum (IDLE/RUN/DONE).
  - Job-type enum (JOB_ST/JOB_KW).
  - Constants `AES_STATE_BYTES`=16 and `AES_WORD_BYTES`=4.
- The S-box sub-module is the existing combinational `S_box` (8-bit in `b`, 8-bit out `b_`), instantiated NSB times in a generate loop. No other sub-module.

## Test plan
- Reset then state job with NSB=4:
  - Stimulus: `st_req_data`=0x193de3bea0f4e22b9ac68d2ae9f84808.
  - Required response: `st_rsp_valid` pulse 5 cycles after accept, data 0xd42711aee0bf98f1b8b45de51e415230.
- Word job:
  - Stimulus: `kw_req_data`=0xcf4f3c09.
  - Required response: `kw_rsp_data`=0x8a84eb01, pulse 2 cycles after accept.
- Simultaneous valid after reset:
  - Key is granted first, then state.
  - Repeated double-pending alternates grants KW, ST, KW.
- Byte sweep:
  - Stimulus: state 0x00 repeated 16 times, then 0xff repeated 16 times.
  - Required response: all bytes 0x63, then all bytes 0x16.
  - Repeat with NSB=1 (latency 17) and NSB=2 (latency 9).
- Reset asserted mid-RUN:
  - No `*_rsp_valid` is issued.
  - Outputs are 0 and ready reasserts in the first cycle after rst drops.
- `SBOX_PIPE_EN` build:
  - Repeat the first two scenarios.
  - Required latencies: 6 and 3 cycles; same data.
